// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: in-order FIFO controller for an external simple-dual-port RAM with
// a 1-cycle registered read, fronted by a 2-entry output buffer.
module ram_fifo_ctrl #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic [ADDR_BITS-1:0] ram_write_address,
    output logic [WIDTH-1:0]     ram_input_data,
    output logic                 ram_write_enable,
    output logic [ADDR_BITS-1:0] ram_read_address,
    input  logic [WIDTH-1:0]     ram_output_data,
    output logic [ADDR_BITS+1:0] count
);
    localparam logic [ADDR_BITS:0] FULL = {1'b1, {ADDR_BITS{1'b0}}};

    logic [ADDR_BITS:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_count, ram_count_d;
    logic               s_ready_q, s_ready_d, inflight_q, inflight_d;
    logic [1:0]         buf_cnt_q, buf_cnt_d, tail;
    logic [WIDTH-1:0]   buf0_q, buf0_d, buf1_q, buf1_d;
    logic               push, pop, issue, capture;

    always_comb begin
        ram_count   = wr_ptr_q - rd_ptr_q;
        push        = s_valid && s_ready_q && !flush;
        pop         = (buf_cnt_q != 2'd0) && m_ready && !flush;
        // a read may only be issued if its word is guaranteed a buffer slot on arrival
        issue       = (ram_count != '0) && !flush &&
                      (({1'b0, buf_cnt_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
        capture     = inflight_q && !flush;
        wr_ptr_d    = flush ? '0 : wr_ptr_q + {{ADDR_BITS{1'b0}}, push};
        rd_ptr_d    = flush ? '0 : rd_ptr_q + {{ADDR_BITS{1'b0}}, issue};
        ram_count_d = wr_ptr_d - rd_ptr_d;
        s_ready_d   = (ram_count_d < FULL) && !flush;
        inflight_d  = issue;
        buf_cnt_d   = flush ? 2'd0 : buf_cnt_q + {1'b0, capture} - {1'b0, pop};
        tail        = buf_cnt_q - {1'b0, pop};
        buf0_d      = pop ? buf1_q : buf0_q;
        buf1_d      = buf1_q;
        if (capture && tail == 2'd0) buf0_d = ram_output_data;
        if (capture && tail != 2'd0) buf1_d = ram_output_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            s_ready_q  <= 1'b0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            s_ready_q  <= s_ready_d;
            inflight_q <= inflight_d;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    assign s_ready           = s_ready_q;
    assign m_valid           = buf_cnt_q != 2'd0;
    assign m_data            = buf0_q;
    assign ram_write_enable  = push;
    assign ram_write_address = wr_ptr_q[ADDR_BITS-1:0];
    assign ram_input_data    = s_data;
    assign ram_read_address  = rd_ptr_q[ADDR_BITS-1:0];
    assign count             = {1'b0, ram_count} + {{(ADDR_BITS+1){1'b0}}, inflight_q}
                             + {{ADDR_BITS{1'b0}}, buf_cnt_q};
endmodule
